ejecutor_movimiento: RTL and testbench

EJECUTOR_MOVIMIENTO -- requirements
Module: ejecutor_movimiento

---
 rtl/ejecutor_movimiento.sv | 174 +++++++++++++++++
 tb/tb_ejecutor_movimiento.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ejecutor_movimiento.sv
// ejecutor_movimiento: executes one elevator command at a time.
// Moves the car exactly one floor per up/down command (floors 0..4), opens
// the door for a fixed time on a stop command, and flags rejected moves.
// Optional build macro SENSOR_PISO_EN: floor arrival comes from the
// sensor_piso input and TIEMPO_PISO becomes a travel timeout. Without it,
// arrival is purely timed (TIEMPO_PISO cycles per floor).
module ejecutor_movimiento #(
  parameter int unsigned TIEMPO_PISO   = 16,
  parameter int unsigned TIEMPO_PUERTA = 8
) (
  input  logic       _clk_,
  input  logic       _reset_,
  input  logic [1:0] accion,
`ifdef SENSOR_PISO_EN
  input  logic       sensor_piso,
`endif
  output logic       FSM_ready_out,
  output logic [2:0] piso_actual,
  output logic       motor_sube,
  output logic       motor_baja,
  output logic       puerta_abierta,
  output logic [4:0] atendido,
  output logic       fuera_rango
);

  typedef enum logic [1:0] {
    REPOSO   = 2'b00,
    SUBIENDO = 2'b01,
    BAJANDO  = 2'b10,
    PUERTA   = 2'b11
  } estado_t;

  localparam logic [15:0] LP_FIN_PISO   = 16'(TIEMPO_PISO - 1);
  localparam logic [15:0] LP_FIN_PUERTA = 16'(TIEMPO_PUERTA - 1);
  localparam logic [2:0]  LP_PISO_MAX   = 3'd4;

  localparam logic [1:0] LP_ACC_ABRIR = 2'b01;
  localparam logic [1:0] LP_ACC_SUBE  = 2'b10;
  localparam logic [1:0] LP_ACC_BAJA  = 2'b11;

  estado_t     r_state;
  estado_t     w_next_state;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic [2:0]  r_piso;
  logic [2:0]  w_piso_next;
  logic [4:0]  r_atendido;
  logic [4:0]  w_atendido_next;
  logic        r_fuera;
  logic        w_fuera_next;
  logic [4:0]  w_onehot;
  logic        w_llegada;
  logic        w_timeout;

  // One-hot decode of the current floor, used for the served-request pulse
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_onehot
      assign w_onehot[gi] = (r_piso == 3'(gi));
    end
  endgenerate

`ifdef SENSOR_PISO_EN
  // Sensor decides arrival; the travel counter only guards against a lost sensor
  assign w_llegada = sensor_piso;
  assign w_timeout = (r_cnt == LP_FIN_PISO) && !sensor_piso;
`else
  // Purely timed travel: arrival after exactly TIEMPO_PISO cycles
  assign w_llegada = (r_cnt == LP_FIN_PISO);
  assign w_timeout = 1'b0;
`endif

  // Next-state, counter, floor and pulse computation
  always_comb begin
    w_next_state    = r_state;
    w_cnt_next      = r_cnt;
    w_piso_next     = r_piso;
    w_atendido_next = 5'b00000;
    w_fuera_next    = 1'b0;
    case (r_state)
      REPOSO: begin
        w_cnt_next = 16'd0;
        case (accion)
          LP_ACC_ABRIR: begin
            w_next_state    = PUERTA;
            w_atendido_next = w_onehot;
          end
          LP_ACC_SUBE: begin
            if (r_piso < LP_PISO_MAX) begin
              w_next_state = SUBIENDO;
            end else begin
              w_fuera_next = 1'b1;
            end
          end
          LP_ACC_BAJA: begin
            if (r_piso != 3'd0) begin
              w_next_state = BAJANDO;
            end else begin
              w_fuera_next = 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
      SUBIENDO: begin
        w_cnt_next = r_cnt + 16'd1;
        if (w_llegada) begin
          w_next_state = REPOSO;
          w_cnt_next   = 16'd0;
          // Clamp keeps the floor in range even if the entry guard were bypassed
          if (r_piso < LP_PISO_MAX) begin
            w_piso_next = r_piso + 3'd1;
          end
        end else if (w_timeout) begin
          w_next_state = REPOSO;
          w_cnt_next   = 16'd0;
          w_fuera_next = 1'b1;
        end
      end
      BAJANDO: begin
        w_cnt_next = r_cnt + 16'd1;
        if (w_llegada) begin
          w_next_state = REPOSO;
          w_cnt_next   = 16'd0;
          if (r_piso != 3'd0) begin
            w_piso_next = r_piso - 3'd1;
          end
        end else if (w_timeout) begin
          w_next_state = REPOSO;
          w_cnt_next   = 16'd0;
          w_fuera_next = 1'b1;
        end
      end
      PUERTA: begin
        w_cnt_next = r_cnt + 16'd1;
        if (r_cnt == LP_FIN_PUERTA) begin
          w_next_state = REPOSO;
          w_cnt_next   = 16'd0;
        end
      end
      default: begin
        w_next_state = REPOSO;
        w_cnt_next   = 16'd0;
      end
    endcase
  end

  // State and datapath registers; reset wins over everything and drops pulses
  always_ff @(posedge _clk_) begin
    if (_reset_) begin
      r_state    <= REPOSO;
      r_cnt      <= 16'd0;
      r_piso     <= 3'd0;
      r_atendido <= 5'b00000;
      r_fuera    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_cnt_next;
      r_piso     <= w_piso_next;
      r_atendido <= w_atendido_next;
      r_fuera    <= w_fuera_next;
    end
  end

  assign FSM_ready_out  = (r_state == REPOSO);
  assign motor_sube     = (r_state == SUBIENDO);
  assign motor_baja     = (r_state == BAJANDO);
  assign puerta_abierta = (r_state == PUERTA);
  assign piso_actual    = r_piso;
  assign atendido       = r_atendido;
  assign fuera_rango    = r_fuera;

endmodule

// File: tb/tb_ejecutor_movimiento.sv
// Testbench for ejecutor_movimiento (TIEMPO_PISO=4, TIEMPO_PUERTA=3).
// Stimulus pushes the hand-computed output snapshot expected after each
// clock edge; an independent monitor pops and compares on the falling edge.
module tb_ejecutor_movimiento;

  localparam int TP = 4;
  localparam int TD = 3;

  typedef struct packed {
    logic       ready;
    logic       sube;
    logic       baja;
    logic       puerta;
    logic [2:0] piso;
    logic [4:0] aten;
    logic       fuera;
  } snap_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] accion;
`ifdef SENSOR_PISO_EN
  logic       sensor;
`endif
  logic       FSM_ready_out;
  logic [2:0] piso_actual;
  logic       motor_sube;
  logic       motor_baja;
  logic       puerta_abierta;
  logic [4:0] atendido;
  logic       fuera_rango;

  snap_t exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 clk = ~clk;

  ejecutor_movimiento #(
    .TIEMPO_PISO  (TP),
    .TIEMPO_PUERTA(TD)
  ) dut (
    ._clk_         (clk),
    ._reset_       (rst),
    .accion        (accion),
`ifdef SENSOR_PISO_EN
    .sensor_piso   (sensor),
`endif
    .FSM_ready_out (FSM_ready_out),
    .piso_actual   (piso_actual),
    .motor_sube    (motor_sube),
    .motor_baja    (motor_baja),
    .puerta_abierta(puerta_abierta),
    .atendido      (atendido),
    .fuera_rango   (fuera_rango)
  );

  function automatic snap_t idle(input logic [2:0] p, input logic f = 1'b0);
    snap_t s;
    s = '{ready: 1'b1, sube: 1'b0, baja: 1'b0, puerta: 1'b0, piso: p, aten: 5'b0, fuera: f};
    return s;
  endfunction

  function automatic snap_t sub(input logic [2:0] p);
    snap_t s;
    s = '{ready: 1'b0, sube: 1'b1, baja: 1'b0, puerta: 1'b0, piso: p, aten: 5'b0, fuera: 1'b0};
    return s;
  endfunction

  function automatic snap_t baj(input logic [2:0] p);
    snap_t s;
    s = '{ready: 1'b0, sube: 1'b0, baja: 1'b1, puerta: 1'b0, piso: p, aten: 5'b0, fuera: 1'b0};
    return s;
  endfunction

  function automatic snap_t door(input logic [2:0] p, input logic [4:0] a);
    snap_t s;
    s = '{ready: 1'b0, sube: 1'b0, baja: 1'b0, puerta: 1'b1, piso: p, aten: a, fuera: 1'b0};
    return s;
  endfunction

  // Apply inputs, let one edge sample them, then queue the expected outputs
  task automatic step(input logic r, input logic [1:0] a, input snap_t e, input string tag);
    rst    = r;
    accion = a;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic move_up(input logic [2:0] p);
    step(1'b0, 2'b10, sub(p), "up_c1");
    step(1'b0, 2'b00, sub(p), "up_c2");
    step(1'b0, 2'b00, sub(p), "up_c3");
    step(1'b0, 2'b00, sub(p), "up_c4");
    step(1'b0, 2'b00, idle(p + 3'd1), "up_arrive");
  endtask

  task automatic move_down(input logic [2:0] p);
    step(1'b0, 2'b11, baj(p), "down_c1");
    step(1'b0, 2'b00, baj(p), "down_c2");
    step(1'b0, 2'b00, baj(p), "down_c3");
    step(1'b0, 2'b00, baj(p), "down_c4");
    step(1'b0, 2'b00, idle(p - 3'd1), "down_arrive");
  endtask

  // Door cycle; an up command issued while the door is open must be ignored
  task automatic door_at(input logic [2:0] p, input logic [4:0] a);
    step(1'b0, 2'b01, door(p, a), "door_open");
    step(1'b0, 2'b10, door(p, 5'b0), "door_c2");
    step(1'b0, 2'b00, door(p, 5'b0), "door_c3");
    step(1'b0, 2'b00, idle(p), "door_closed");
  endtask

  // Monitor: compares every queued expectation against the live outputs
  always @(negedge clk) begin
    snap_t e;
    snap_t a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {FSM_ready_out, motor_sube, motor_baja, puerta_abierta, piso_actual, atendido, fuera_rango};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL %s: got rdy=%b up=%b dn=%b door=%b piso=%0d aten=%b fuera=%b, want rdy=%b up=%b dn=%b door=%b piso=%0d aten=%b fuera=%b",
                 t, a.ready, a.sube, a.baja, a.puerta, a.piso, a.aten, a.fuera,
                 e.ready, e.sube, e.baja, e.puerta, e.piso, e.aten, e.fuera);
      end else begin
        $display("ok   %s: rdy=%b up=%b dn=%b door=%b piso=%0d aten=%b fuera=%b",
                 t, a.ready, a.sube, a.baja, a.puerta, a.piso, a.aten, a.fuera);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    accion = 2'b00;
`ifdef SENSOR_PISO_EN
    sensor = 1'b0;
`endif
    step(1'b1, 2'b00, idle(3'd0), "reset");
    step(1'b1, 2'b10, idle(3'd0), "reset_over_cmd");
    step(1'b0, 2'b00, idle(3'd0), "idle_none");

`ifdef SENSOR_PISO_EN
    // Arrival on the sensor during the second travel cycle
    step(1'b0, 2'b10, sub(3'd0), "s_up_c1");
    step(1'b0, 2'b00, sub(3'd0), "s_up_c2");
    sensor = 1'b1;
    step(1'b0, 2'b00, idle(3'd1), "s_arrive");
    sensor = 1'b0;
    step(1'b0, 2'b00, idle(3'd1), "s_idle");
    // No sensor: timeout after TP cycles, floor kept, fuera_rango pulse
    step(1'b0, 2'b10, sub(3'd1), "s_to_c1");
    step(1'b0, 2'b00, sub(3'd1), "s_to_c2");
    step(1'b0, 2'b00, sub(3'd1), "s_to_c3");
    step(1'b0, 2'b00, sub(3'd1), "s_to_c4");
    step(1'b0, 2'b00, idle(3'd1, 1'b1), "s_timeout");
    step(1'b0, 2'b00, idle(3'd1), "s_timeout_clr");
    // Downward arrival on the first travel cycle
    step(1'b0, 2'b11, baj(3'd1), "s_dn_c1");
    sensor = 1'b1;
    step(1'b0, 2'b00, idle(3'd0), "s_dn_arrive");
    sensor = 1'b0;
    step(1'b0, 2'b11, idle(3'd0, 1'b1), "s_down_at_0");
    step(1'b0, 2'b00, idle(3'd0), "s_fuera_clr");
`else
    // Lower boundary: rejected down move and door at floor 0
    step(1'b0, 2'b11, idle(3'd0, 1'b1), "down_at_0");
    step(1'b0, 2'b00, idle(3'd0), "fuera_clr0");
    door_at(3'd0, 5'b00001);
    // Climb to the top floor one floor per command
    move_up(3'd0);
    move_up(3'd1);
    move_up(3'd2);
    move_up(3'd3);
    step(1'b0, 2'b10, idle(3'd4, 1'b1), "up_at_4");
    step(1'b0, 2'b00, idle(3'd4), "fuera_clr4");
    door_at(3'd4, 5'b10000);
    move_down(3'd4);
    // Commands toggled during travel are ignored
    step(1'b0, 2'b11, baj(3'd3), "tog_c1");
    step(1'b0, 2'b10, baj(3'd3), "tog_c2");
    step(1'b0, 2'b00, baj(3'd3), "tog_c3");
    step(1'b0, 2'b10, baj(3'd3), "tog_c4");
    step(1'b0, 2'b10, idle(3'd2), "tog_arrive");
    door_at(3'd2, 5'b00100);
    move_down(3'd2);
    // Reset during the second travel cycle aborts the move
    step(1'b0, 2'b11, baj(3'd1), "rmove_c1");
    step(1'b0, 2'b00, baj(3'd1), "rmove_c2");
    step(1'b1, 2'b00, idle(3'd0), "reset_mid_move");
    step(1'b0, 2'b00, idle(3'd0), "after_rmove");
    // Reset while the door is open: no further atendido pulse, floor cleared
    move_up(3'd0);
    step(1'b0, 2'b01, door(3'd1, 5'b00010), "rdoor_open");
    step(1'b1, 2'b00, idle(3'd0), "reset_mid_door");
    step(1'b0, 2'b00, idle(3'd0), "after_rdoor");
`endif

    accion = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
